row_vnu_msg_scheduler: RTL and testbench

Parametrised row-level variable-node front end for the layered IB decoder. It latches one row's channel and c2v messages for CN_DEGREE VNUs of any VN_DEGREE through a valid/ready handshake, then issues them to the external fixed-latency IB-LUT VNU/DNU datapath with a multi-frame tag. It realigns the returned v2c and hard-decision results into a single output beat. It also owns the iteration-refresh sequencer that reloads IB-RAM pages from IB-ROM; the sequencer drains the pipeline first and blocks new input while it runs.

---
 rtl/row_vnu_msg_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_row_vnu_msg_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_vnu_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : row_vnu_msg_scheduler
// Description : Row-level VNU front end: latches c2v/channel messages, issues
//               them to the fixed-latency IB-LUT datapath, realigns v2c/hd
//               results, and sequences IB-RAM page refresh from IB-ROM.
//               Optional macro ROW_VNU_PARALLEL_CLEAR_EN adds in_clear.
// Revision    : 1.0 - initial release
// ============================================================================
module row_vnu_msg_scheduler #(
    parameter  int QUAN_SIZE       = 4,
    parameter  int CN_DEGREE       = 10,
    parameter  int VN_DEGREE       = 3,
    parameter  int MULTI_FRAME_NUM = 2,
    parameter  int VN_LAT          = 3,
    parameter  int DN_LAT          = 3,
    parameter  int RAM_NUM         = 3,
    parameter  int PAGE_NUM        = 64,
    parameter  int ROM_RD_BW       = 8,
    localparam int FRAME_BW        = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1,
    localparam int PAGE_ADDR_BW    = $clog2(PAGE_NUM),
    localparam int RAM_BW          = (RAM_NUM > 1) ? $clog2(RAM_NUM) : 1,
    localparam int C2V_BW          = CN_DEGREE * VN_DEGREE * QUAN_SIZE,
    localparam int MSG_BW          = CN_DEGREE * QUAN_SIZE
) (
    input  logic                           read_clk,
    input  logic                           rst,
    input  logic                           in_valid,
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
    input  logic                           in_clear,
`endif
    output logic                           in_ready,
    input  logic [C2V_BW-1:0]              in_c2v,
    input  logic [MSG_BW-1:0]              in_ch,
    output logic                           vnu_issue_valid,
    output logic [C2V_BW-1:0]              vnu_c2v,
    output logic [MSG_BW-1:0]              vnu_ch,
    output logic [FRAME_BW-1:0]            vnu_frame,
    input  logic [MSG_BW-1:0]              vnu_v2c_in,
    input  logic [CN_DEGREE-1:0]           vnu_hd_in,
    output logic                           out_valid,
    output logic [MSG_BW-1:0]              out_v2c,
    output logic [CN_DEGREE-1:0]           out_hd,
    output logic [FRAME_BW-1:0]            out_frame,
    input  logic                           refresh_start,
    output logic                           refresh_busy,
    output logic                           refresh_done,
    output logic [PAGE_ADDR_BW+RAM_BW-1:0] rom_addr,
    input  logic [ROM_RD_BW-1:0]           rom_data,
    output logic [PAGE_ADDR_BW-1:0]        ram_waddr,
    output logic [ROM_RD_BW-1:0]           ram_wdata,
    output logic [RAM_NUM-1:0]             ib_ram_we
);

    localparam int TAG_DEPTH = VN_LAT + DN_LAT;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DRAIN = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_FLUSH = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [PAGE_ADDR_BW-1:0] c_PAGE_LAST  = PAGE_ADDR_BW'(PAGE_NUM - 1);
    localparam logic [RAM_BW-1:0]       c_RAM_LAST   = RAM_BW'(RAM_NUM - 1);
    localparam logic [FRAME_BW-1:0]     c_FRAME_LAST = FRAME_BW'(MULTI_FRAME_NUM - 1);

    logic [2:0]              r_state;
    logic [FRAME_BW-1:0]     r_frame_cnt;
    logic                    r_issue_valid;
    logic [C2V_BW-1:0]       r_vnu_c2v;
    logic [MSG_BW-1:0]       r_vnu_ch;
    logic [FRAME_BW-1:0]     r_vnu_frame;
    logic [TAG_DEPTH-1:0]    r_tag_valid;
    logic [FRAME_BW-1:0]     r_tag_frame [TAG_DEPTH];
    logic [MSG_BW-1:0]       r_v2c_dly   [DN_LAT];
    logic                    r_out_valid;
    logic [MSG_BW-1:0]       r_out_v2c;
    logic [CN_DEGREE-1:0]    r_out_hd;
    logic [FRAME_BW-1:0]     r_out_frame;
    logic [RAM_BW-1:0]       r_ram;
    logic [PAGE_ADDR_BW-1:0] r_page;
    logic [RAM_NUM-1:0]      r_we;
    logic [PAGE_ADDR_BW-1:0] r_waddr;

    logic                    w_accept;
    logic                    w_pipe_empty;
    logic [C2V_BW-1:0]       w_c2v_load;
    logic [FRAME_BW-1:0]     w_frame_next;

    assign in_ready     = (r_state == c_ST_IDLE) && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_pipe_empty = (r_tag_valid == '0) && !r_issue_valid;
    assign w_frame_next = (r_frame_cnt == c_FRAME_LAST) ? '0 : r_frame_cnt + FRAME_BW'(1);

`ifdef ROW_VNU_PARALLEL_CLEAR_EN
    // First-iteration rows start from zero c2v without the host clearing them.
    assign w_c2v_load = in_clear ? '0 : in_c2v;
`else
    assign w_c2v_load = in_c2v;
`endif

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_vnu_c2v     <= '0;
            r_vnu_ch      <= '0;
            r_vnu_frame   <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_issue_valid <= w_accept;
            if (w_accept) begin
                r_vnu_c2v   <= w_c2v_load;
                r_vnu_ch    <= in_ch;
                r_vnu_frame <= r_frame_cnt;
            end
            if (r_state == c_ST_DONE) begin
                r_frame_cnt <= '0;
            end else if (w_accept) begin
                r_frame_cnt <= w_frame_next;
            end
        end
    end

    // Tag stage k holds the issue launched k+1 cycles earlier; v2c is free-run
    // delayed so its tail lines up with the hd sample at the last tag stage.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_tag_valid <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) r_tag_frame[i] <= '0;
            for (int i = 0; i < DN_LAT; i++)    r_v2c_dly[i]   <= '0;
            r_out_valid <= 1'b0;
            r_out_v2c   <= '0;
            r_out_hd    <= '0;
            r_out_frame <= '0;
        end else begin
            r_tag_valid[0] <= r_issue_valid;
            r_tag_frame[0] <= r_vnu_frame;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_frame[i] <= r_tag_frame[i-1];
            end
            r_v2c_dly[0] <= vnu_v2c_in;
            for (int i = 1; i < DN_LAT; i++) r_v2c_dly[i] <= r_v2c_dly[i-1];
            r_out_valid <= r_tag_valid[TAG_DEPTH-1];
            if (r_tag_valid[TAG_DEPTH-1]) begin
                r_out_v2c   <= r_v2c_dly[DN_LAT-1];
                r_out_hd    <= vnu_hd_in;
                r_out_frame <= r_tag_frame[TAG_DEPTH-1];
            end
        end
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ram   <= '0;
            r_page  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (refresh_start) r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= c_ST_WRITE;
                        r_ram   <= '0;
                        r_page  <= '0;
                    end
                end
                c_ST_WRITE: begin
                    if (r_page == c_PAGE_LAST) begin
                        r_page <= '0;
                        if (r_ram == c_RAM_LAST) begin
                            r_ram   <= '0;
                            r_state <= c_ST_FLUSH;
                        end else begin
                            r_ram <= r_ram + RAM_BW'(1);
                        end
                    end else begin
                        r_page <= r_page + PAGE_ADDR_BW'(1);
                    end
                end
                c_ST_FLUSH: r_state <= c_ST_DONE;
                c_ST_DONE:  r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ROM data returns one cycle after the address, so the write side trails.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_we    <= '0;
            r_waddr <= '0;
        end else begin
            r_we <= (r_state == c_ST_WRITE) ? (RAM_NUM'(1) << r_ram) : '0;
            if (r_state == c_ST_WRITE) r_waddr <= r_page;
        end
    end

    assign vnu_issue_valid = r_issue_valid;
    assign vnu_c2v         = r_vnu_c2v;
    assign vnu_ch          = r_vnu_ch;
    assign vnu_frame       = r_vnu_frame;
    assign out_valid       = r_out_valid;
    assign out_v2c         = r_out_v2c;
    assign out_hd          = r_out_hd;
    assign out_frame       = r_out_frame;
    assign refresh_busy    = (r_state != c_ST_IDLE);
    assign refresh_done    = (r_state == c_ST_DONE);
    assign rom_addr        = (r_state == c_ST_WRITE) ? {r_ram, r_page} : '0;
    assign ram_waddr       = r_waddr;
    assign ram_wdata       = (|r_we) ? rom_data : '0;
    assign ib_ram_we       = r_we;

endmodule
`default_nettype wire

// File: tb/tb_row_vnu_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_vnu_msg_scheduler
// Description : Directed + random bench for row_vnu_msg_scheduler against a
//               cycle-indexed transaction model and a synchronous ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_vnu_msg_scheduler;

    localparam int NCYC   = 4096;
    localparam int LAT    = 7;      // accept -> hd sample cycle
    localparam int NWRITE = 192;

    logic         read_clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
    logic         in_clear = 1'b0;
`endif
    logic         in_ready;
    logic [119:0] in_c2v = '0;
    logic [39:0]  in_ch = '0;
    logic         vnu_issue_valid;
    logic [119:0] vnu_c2v;
    logic [39:0]  vnu_ch;
    logic         vnu_frame;
    logic [39:0]  vnu_v2c_in = '0;
    logic [9:0]   vnu_hd_in = '0;
    logic         out_valid;
    logic [39:0]  out_v2c;
    logic [9:0]   out_hd;
    logic         out_frame;
    logic         refresh_start = 1'b0;
    logic         refresh_busy;
    logic         refresh_done;
    logic [7:0]   rom_addr;
    logic [7:0]   rom_data = '0;
    logic [5:0]   ram_waddr;
    logic [7:0]   ram_wdata;
    logic [2:0]   ib_ram_we;

    always #5 read_clk = ~read_clk;

    row_vnu_msg_scheduler dut (
        .read_clk        (read_clk),
        .rst             (rst),
        .in_valid        (in_valid),
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
        .in_clear        (in_clear),
`endif
        .in_ready        (in_ready),
        .in_c2v          (in_c2v),
        .in_ch           (in_ch),
        .vnu_issue_valid (vnu_issue_valid),
        .vnu_c2v         (vnu_c2v),
        .vnu_ch          (vnu_ch),
        .vnu_frame       (vnu_frame),
        .vnu_v2c_in      (vnu_v2c_in),
        .vnu_hd_in       (vnu_hd_in),
        .out_valid       (out_valid),
        .out_v2c         (out_v2c),
        .out_hd          (out_hd),
        .out_frame       (out_frame),
        .refresh_start   (refresh_start),
        .refresh_busy    (refresh_busy),
        .refresh_done    (refresh_done),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .ram_waddr       (ram_waddr),
        .ram_wdata       (ram_wdata),
        .ib_ram_we       (ib_ram_we)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit check_en = 1'b0;
    int we_cnt = 0;
    int done_cnt = 0;

    // Per-cycle history of accepted beats and datapath return values.
    bit           acc       [NCYC];
    bit           acc_clr   [NCYC];
    int           acc_frame [NCYC];
    logic [119:0] acc_c2v   [NCYC];
    logic [39:0]  acc_ch    [NCYC];
    logic [39:0]  v2c_hist  [NCYC];
    logic [9:0]   hd_hist   [NCYC];

    int  last_rst = -1;
    int  last_acc = -100;
    int  frame_cnt = 0;
    bit  ref_active = 1'b0;
    int  ref_req = 0;
    int  ref_w = 0;       // first cycle rom_addr carries a WRITE address

    bit           exp_issue = 1'b0;
    logic [119:0] exp_c2v = '0;
    logic [39:0]  exp_ch = '0;
    logic         exp_vframe = 1'b0;
    bit           exp_ov = 1'b0;
    logic [39:0]  exp_ov2c = '0;
    logic [9:0]   exp_ohd = '0;
    logic         exp_oframe = 1'b0;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        logic [7:0] r;
        r = 8'(a * 8'd29 + 8'd7);
        return r ^ 8'h5A;
    endfunction

    function automatic bit busy(input int c);
        return ref_active && (c > ref_req) && (c <= ref_w + NWRITE + 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int k;
        logic [2:0] e_we;
        chk("in_ready", 128'(in_ready), 128'(!rst && !busy(cyc)));
        chk("issue_valid", 128'(vnu_issue_valid), 128'(exp_issue));
        chk("vnu_c2v", 128'(vnu_c2v), 128'(exp_c2v));
        chk("vnu_ch", 128'(vnu_ch), 128'(exp_ch));
        chk("vnu_frame", 128'(vnu_frame), 128'(exp_vframe));
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        chk("out_v2c", 128'(out_v2c), 128'(exp_ov2c));
        chk("out_hd", 128'(out_hd), 128'(exp_ohd));
        chk("out_frame", 128'(out_frame), 128'(exp_oframe));
        chk("refresh_busy", 128'(refresh_busy), 128'(busy(cyc)));
        chk("refresh_done", 128'(refresh_done), 128'(ref_active && cyc == ref_w + NWRITE + 1));
        k = cyc - ref_w;
        chk("rom_addr", 128'(rom_addr), (ref_active && k >= 0 && k < NWRITE) ? 128'(k) : 128'(0));
        k = cyc - ref_w - 1;
        e_we = (ref_active && k >= 0 && k < NWRITE) ? 3'(1 << (k / 64)) : 3'b000;
        chk("ib_ram_we", 128'(ib_ram_we), 128'(e_we));
        if (e_we != 3'b000) begin
            chk("ram_waddr", 128'(ram_waddr), 128'(k % 64));
            chk("ram_wdata", 128'(ram_wdata), 128'(rom_fn(8'(k))));
        end else begin
            chk("ram_wdata_idle", 128'(ram_wdata), 128'(0));
        end
        if (|ib_ram_we) we_cnt++;
        if (refresh_done) done_cnt++;
    endtask

    task automatic tick();
        logic [7:0] prev_addr;
        bit rst_now;
        int t;
        #1;
        if (check_en) check_cycle();
        if (in_valid && !rst && !busy(cyc)) begin
            acc[cyc]       = 1'b1;
            acc_c2v[cyc]   = in_c2v;
            acc_ch[cyc]    = in_ch;
            acc_frame[cyc] = frame_cnt;
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
            acc_clr[cyc]   = in_clear;
`else
            acc_clr[cyc]   = 1'b0;
`endif
            frame_cnt = (frame_cnt + 1) % 2;
            last_acc  = cyc;
        end
        if (refresh_start && !rst && !busy(cyc)) begin
            ref_active = 1'b1;
            ref_req    = cyc;
            ref_w      = (cyc + 2 > last_acc + LAT + 2) ? cyc + 2 : last_acc + LAT + 2;
        end
        rst_now   = rst;
        prev_addr = rom_addr;
        @(posedge read_clk);
        #1;
        cyc++;
        if (cyc >= NCYC - 1) begin
            $display("FAIL cycle_budget: observed %0d cycles expected below %0d", cyc, NCYC - 1);
            $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
            $fatal(1, "cycle budget exhausted");
        end
        rom_data      = rom_fn(prev_addr);
        vnu_v2c_in    = 40'({$urandom(), $urandom()});
        vnu_hd_in     = 10'($urandom());
        v2c_hist[cyc] = vnu_v2c_in;
        hd_hist[cyc]  = vnu_hd_in;
        if (rst_now) begin
            last_rst   = cyc - 1;
            ref_active = 1'b0;
            frame_cnt  = 0;
            last_acc   = -100;
            exp_c2v    = '0;
            exp_ch     = '0;
            exp_vframe = 1'b0;
            exp_ov2c   = '0;
            exp_ohd    = '0;
            exp_oframe = 1'b0;
        end
        if (ref_active && cyc == ref_w + NWRITE + 1) frame_cnt = 0;
        t = cyc - 1;
        exp_issue = (t >= 0) && (t > last_rst) && acc[t];
        if (exp_issue) begin
            exp_c2v    = acc_clr[t] ? 120'd0 : acc_c2v[t];
            exp_ch     = acc_ch[t];
            exp_vframe = acc_frame[t][0];
        end
        t = cyc - LAT - 1;
        exp_ov = (t >= 0) && (t > last_rst) && acc[t];
        if (exp_ov) begin
            exp_ov2c   = v2c_hist[cyc - 4];
            exp_ohd    = hd_hist[cyc - 1];
            exp_oframe = acc_frame[t][0];
        end
    endtask

    task automatic set_v2c(input logic [39:0] v);
        vnu_v2c_in    = v;
        v2c_hist[cyc] = v;
    endtask

    task automatic set_hd(input logic [9:0] h);
        vnu_hd_in    = h;
        hd_hist[cyc] = h;
    endtask

    task automatic wait_refresh();
        for (int i = 0; i < 700 && busy(cyc); i++) tick();
        chk("refresh_finished", 128'(refresh_busy), 128'(0));
    endtask

    initial begin
        // Reset
        tick();
        check_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single directed beat through the full latency
        in_valid = 1'b1;
        in_c2v   = {30{4'h5}};
        in_ch    = {10{4'h3}};
        tick();
        in_valid = 1'b0;
        chk("t1_issue", 128'(vnu_issue_valid), 128'(1));
        chk("t1_c2v", 128'(vnu_c2v), 128'({30{4'h5}}));
        chk("t1_ch", 128'(vnu_ch), 128'({10{4'h3}}));
        chk("t1_frame", 128'(vnu_frame), 128'(0));
        tick(); tick(); tick();
        set_v2c({10{4'hA}});
        tick(); tick(); tick();
        set_hd(10'h2AA);
        tick();
        chk("t1_out_valid", 128'(out_valid), 128'(1));
        chk("t1_out_v2c", 128'(out_v2c), 128'({10{4'hA}}));
        chk("t1_out_hd", 128'(out_hd), 128'(10'h2AA));
        chk("t1_out_frame", 128'(out_frame), 128'(0));
        tick();

        // Re-home the frame counter, then five back-to-back beats
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_c2v   = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
            in_ch    = 40'({$urandom(), $urandom()});
            tick();
            chk("b2b_vnu_frame", 128'(vnu_frame), 128'(i % 2));
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("b2b_out_valid", 128'(out_valid), 128'(1));
            chk("b2b_out_frame", 128'(out_frame), 128'(i % 2));
            tick();
        end

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_c2v   = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
            in_ch    = 40'({$urandom(), $urandom()});
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
            in_clear = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        in_valid = 1'b0;
`ifdef ROW_VNU_PARALLEL_CLEAR_EN
        in_clear = 1'b0;
`endif
        tick();

        // Refresh requested one cycle after an accept
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        refresh_start = 1'b1;
        tick();
        refresh_start = 1'b0;
        we_cnt   = 0;
        done_cnt = 0;
        #1;
        chk("refresh_blocks_ready", 128'(in_ready), 128'(0));
        wait_refresh();
        chk("refresh_we_cycles", 128'(we_cnt), 128'(NWRITE));
        chk("refresh_done_pulses", 128'(done_cnt), 128'(1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_refresh_frame", 128'(vnu_frame), 128'(0));
        tick(); tick();

        // Accept and refresh request in the same cycle
        in_valid = 1'b1;
        refresh_start = 1'b1;
        tick();
        in_valid = 1'b0;
        refresh_start = 1'b0;
        chk("same_cycle_issue", 128'(vnu_issue_valid), 128'(1));
        we_cnt   = 0;
        done_cnt = 0;
        wait_refresh();
        chk("same_cycle_we_cycles", 128'(we_cnt), 128'(NWRITE));
        chk("same_cycle_done", 128'(done_cnt), 128'(1));

        // Reset in the middle of the WRITE phase
        refresh_start = 1'b1;
        tick();
        refresh_start = 1'b0;
        for (int i = 0; i < 400 && cyc < ref_w + 20; i++) tick();
        chk("mid_write_page", 128'(rom_addr), 128'(20));
        done_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_we", 128'(ib_ram_we), 128'(0));
        chk("rst_rom_addr", 128'(rom_addr), 128'(0));
        chk("rst_waddr", 128'(ram_waddr), 128'(0));
        chk("rst_busy", 128'(refresh_busy), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 10; i++) tick();
        chk("rst_no_done", 128'(done_cnt), 128'(0));

`ifdef ROW_VNU_PARALLEL_CLEAR_EN
        in_valid = 1'b1;
        in_clear = 1'b1;
        in_c2v   = {30{4'hF}};
        in_ch    = 40'h12_3456_789A;
        tick();
        in_valid = 1'b0;
        in_clear = 1'b0;
        chk("clear_c2v", 128'(vnu_c2v), 128'(0));
        chk("clear_ch", 128'(vnu_ch), 128'(40'h12_3456_789A));
`endif

        for (int i = 0; i < 12; i++) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
